// File: rtl/types.sv
// Flit layout and checksum constants for the router tail.
// The checksum byte is recomputed as the flit leaves the router.
package types;

  localparam int DEST_W = 8;
  localparam int DATA_W = 16;
  localparam int CSUM_W = 8;

  localparam logic [CSUM_W-1:0] CSUM_SEED = 8'h5A;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] payload;
    logic [CSUM_W-1:0] csum;
  } flit_t;

endpackage

// File: rtl/calculate_checksum_comb.sv
// Overwrites the flit checksum with the seeded XOR
// of the destination and both payload bytes.
module calculate_checksum_comb
  import types::*;
(
  input  flit_t flit_in,
  output flit_t flit_out
);

  logic [CSUM_W-1:0] sum;

  assign sum = CSUM_SEED
             ^ flit_in.dest
             ^ flit_in.payload[15:8]
             ^ flit_in.payload[7:0];

  always_comb begin
    flit_out      = flit_in;
    flit_out.csum = sum;
  end

endmodule

// File: rtl/noc_flit_merge.sv
// Merges the system channel and N normal channels into one
// registered, checksummed output stream.
module noc_flit_merge
  import types::*;
#(
  parameter int NUM_NORMAL   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  nocclk,
  input  logic                  rst,
  input  flit_t                 in_system_flit,
  input  logic                  in_system_flit_valid,
  output logic                  in_system_flit_ready,
  input  flit_t                 in_normal_flit [NUM_NORMAL],
  input  logic [NUM_NORMAL-1:0] in_normal_flit_valid,
  output logic [NUM_NORMAL-1:0] in_normal_flit_ready,
  output flit_t                 out_flit,
  output logic                  out_flit_valid,
  input  logic                  out_flit_ready
);

  localparam int PW =
    (NUM_NORMAL > 1) ? $clog2(NUM_NORMAL) : 1;
  localparam int SW =
    (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [PW-1:0] LAST  = PW'(NUM_NORMAL - 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // First valid index at or after ptr, wrapping.
  function automatic logic [PW-1:0] rr_pick(
    input logic [NUM_NORMAL-1:0] v,
    input logic [PW-1:0]         ptr
  );
    logic [PW-1:0] pick;
    int            idx;
    pick = ptr;
    for (int k = NUM_NORMAL - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_NORMAL;
      if (v[idx]) pick = PW'(idx);
    end
    return pick;
  endfunction

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         win;
  logic [SW-1:0]         streak;
  logic                  load;
  logic                  accept;
  logic                  any_norm;
  logic                  guard;
  logic                  sys_grant;
  logic                  norm_grant;
  logic                  any_grant;
  logic                  sys_xfer;
  logic                  norm_xfer;
  logic [NUM_NORMAL-1:0] norm_onehot;
  flit_t                 sel_flit;
  flit_t                 csum_flit;

  assign load     = !out_flit_valid || out_flit_ready;
  assign accept   = load && !rst;
  assign any_norm = |in_normal_flit_valid;
  assign win      = rr_pick(in_normal_flit_valid, rr_ptr);

  assign guard = (STARVE_LIMIT != 0)
              && (streak == LIMIT)
              && any_norm;

  assign sys_grant  = in_system_flit_valid && !guard;
  assign norm_grant = any_norm && !sys_grant;
  assign any_grant  = sys_grant || norm_grant;

  assign sys_xfer  = sys_grant && accept;
  assign norm_xfer = norm_grant && accept;

  always_comb begin
    norm_onehot = '0;
    for (int i = 0; i < NUM_NORMAL; i++) begin
      norm_onehot[i] = norm_grant && (win == PW'(i));
    end
  end

  assign in_system_flit_ready = sys_xfer;
  assign in_normal_flit_ready =
    norm_onehot & {NUM_NORMAL{accept}};

  always_comb begin
    sel_flit = '0;
    unique case (1'b1)
      sys_grant:  sel_flit = in_system_flit;
      norm_grant: sel_flit = in_normal_flit[win];
      default:    sel_flit = '0;
    endcase
  end

  calculate_checksum_comb u_csum (
    .flit_in  (sel_flit),
    .flit_out (csum_flit)
  );

  always_ff @(posedge nocclk) begin
    if (rst) begin
      out_flit_valid <= 1'b0;
      out_flit       <= '0;
    end else if (load) begin
      out_flit_valid <= any_grant;
      if (any_grant) out_flit <= csum_flit;
    end
  end

  always_ff @(posedge nocclk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (norm_xfer) begin
      rr_ptr <= (win == LAST) ? '0 : win + PW'(1);
    end
  end

  // Idle normals reset the streak so the guard only
  // counts system grants made against real contention.
  always_ff @(posedge nocclk) begin
    if (rst) begin
      streak <= '0;
    end else if (norm_xfer || !any_norm) begin
      streak <= '0;
    end else if (sys_xfer && streak != LIMIT) begin
      streak <= streak + SW'(1);
    end
  end

endmodule

// File: tb/tb_noc_flit_merge.sv
// Directed bench for noc_flit_merge: arbitration order,
// starvation guard, backpressure and reset behaviour.
module tb_noc_flit_merge;
  import types::*;

  localparam int N = 3;

  logic         nocclk;
  logic         rst;
  flit_t        sys_f;
  logic         sv;
  logic         s_rdy;
  logic         s_rdy0;
  flit_t        nf [N];
  logic [N-1:0] nv;
  logic [N-1:0] n_rdy;
  logic [N-1:0] n_rdy0;
  flit_t        o_f;
  flit_t        o_f0;
  logic         o_v;
  logic         o_v0;
  logic         ordy;

  flit_t        sys_exp;
  flit_t        nexp [N];

  int checks;
  int failures;

  noc_flit_merge #(
    .NUM_NORMAL   (N),
    .STARVE_LIMIT (4)
  ) dut (
    .nocclk               (nocclk),
    .rst                  (rst),
    .in_system_flit       (sys_f),
    .in_system_flit_valid (sv),
    .in_system_flit_ready (s_rdy),
    .in_normal_flit       (nf),
    .in_normal_flit_valid (nv),
    .in_normal_flit_ready (n_rdy),
    .out_flit             (o_f),
    .out_flit_valid       (o_v),
    .out_flit_ready       (ordy)
  );

  noc_flit_merge #(
    .NUM_NORMAL   (N),
    .STARVE_LIMIT (0)
  ) dut0 (
    .nocclk               (nocclk),
    .rst                  (rst),
    .in_system_flit       (sys_f),
    .in_system_flit_valid (sv),
    .in_system_flit_ready (s_rdy0),
    .in_normal_flit       (nf),
    .in_normal_flit_valid (nv),
    .in_normal_flit_ready (n_rdy0),
    .out_flit             (o_f0),
    .out_flit_valid       (o_v0),
    .out_flit_ready       (ordy)
  );

  initial begin
    nocclk = 1'b0;
    forever #5 nocclk = ~nocclk;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic         s,
    input logic [N-1:0] n,
    input logic         r
  );
    sv   = s;
    nv   = n;
    ordy = r;
  endtask

  task automatic expect_rdy(
    input string        tag,
    input logic         s,
    input logic [N-1:0] n
  );
    #1;
    check({tag, "_srdy"}, 32'(s_rdy), 32'(s));
    check({tag, "_nrdy"}, 32'(n_rdy), 32'(n));
  endtask

  task automatic expect_out(
    input string tag,
    input logic  v,
    input flit_t f
  );
    @(negedge nocclk);
    check({tag, "_ovld"}, 32'(o_v), 32'(v));
    check({tag, "_oflit"}, o_f, f);
  endtask

  initial begin
    logic sys_turn;
    checks   = 0;
    failures = 0;

    sys_f = '{dest: 8'hF0, payload: 16'hABCD, csum: 8'h00};
    nf[0] = '{dest: 8'h10, payload: 16'h1234, csum: 8'h00};
    nf[1] = '{dest: 8'h11, payload: 16'h5678, csum: 8'h00};
    nf[2] = '{dest: 8'h12, payload: 16'h9ABC, csum: 8'h00};
    sys_exp = 32'hF0ABCDCC;
    nexp[0] = 32'h1012346C;
    nexp[1] = 32'h11567865;
    nexp[2] = 32'h129ABC6E;

    rst = 1'b1;
    drive(1'b1, 3'b111, 1'b1);
    @(negedge nocclk);
    expect_rdy("rst", 1'b0, 3'b000);
    check("rst0_srdy", 32'(s_rdy0), 32'd0);
    expect_out("rst", 1'b0, '0);

    rst = 1'b0;
    drive(1'b0, 3'b111, 1'b1);
    for (int k = 0; k < 6; k++) begin
      expect_rdy("rr", 1'b0, 3'(1 << (k % 3)));
      expect_out("rr", 1'b1, nexp[k % 3]);
    end

    drive(1'b0, 3'b001, 1'b1);
    expect_rdy("single", 1'b0, 3'b001);
    expect_out("single", 1'b1, nexp[0]);
    drive(1'b0, 3'b000, 1'b1);
    expect_rdy("idle", 1'b0, 3'b000);
    expect_out("idle", 1'b0, nexp[0]);

    drive(1'b1, 3'b010, 1'b0);
    expect_rdy("fill", 1'b1, 3'b000);
    expect_out("fill", 1'b1, sys_exp);
    for (int k = 0; k < 5; k++) begin
      expect_rdy("bp", 1'b0, 3'b000);
      expect_out("bp", 1'b1, sys_exp);
    end
    drive(1'b0, 3'b010, 1'b1);
    expect_rdy("release", 1'b0, 3'b010);
    expect_out("release", 1'b1, nexp[1]);

    drive(1'b1, 3'b010, 1'b1);
    for (int k = 0; k < 10; k++) begin
      sys_turn = (k % 5) != 4;
      expect_rdy("guard", sys_turn,
                 sys_turn ? 3'b000 : 3'b010);
      check("nog_srdy", 32'(s_rdy0), 32'd1);
      check("nog_nrdy", 32'(n_rdy0), 32'd0);
      expect_out("guard", 1'b1,
                 sys_turn ? sys_exp : nexp[1]);
      check("nog_oflit", o_f0, sys_exp);
    end

    for (int k = 0; k < 2; k++) begin
      expect_rdy("pre", 1'b1, 3'b000);
      expect_out("pre", 1'b1, sys_exp);
    end
    drive(1'b1, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      expect_rdy("sysonly", 1'b1, 3'b000);
      expect_out("sysonly", 1'b1, sys_exp);
    end
    drive(1'b1, 3'b010, 1'b1);
    for (int k = 0; k < 5; k++) begin
      sys_turn = k != 4;
      expect_rdy("clr", sys_turn,
                 sys_turn ? 3'b000 : 3'b010);
      expect_out("clr", 1'b1,
                 sys_turn ? sys_exp : nexp[1]);
    end

    rst = 1'b1;
    drive(1'b1, 3'b111, 1'b0);
    expect_rdy("midrst", 1'b0, 3'b000);
    @(negedge nocclk);
    rst = 1'b0;
    drive(1'b0, 3'b000, 1'b1);
    check("midrst_ovld", 32'(o_v), 32'd0);
    check("midrst_oflit", o_f, 32'd0);
    expect_rdy("postrst", 1'b0, 3'b000);
    @(negedge nocclk);
    drive(1'b0, 3'b111, 1'b1);
    expect_rdy("firstrr", 1'b0, 3'b001);
    expect_out("firstrr", 1'b1, nexp[0]);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
